// File: rtl/dm_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// dm_arbiter_pkg
// Shared definitions for the CPU/DMA memory arbiter:
//   - FSM state encoding (IDLE, ACC0, ACC1)
//   - port index constants used by the round-robin pointer
//   - default width of the port-1 burst length field
// ---------------------------------------------------------------------------
package dm_arbiter_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ACC0 = 2'd1;
    localparam logic [1:0] ST_ACC1 = 2'd2;

    localparam logic PORT0 = 1'b0;
    localparam logic PORT1 = 1'b1;

    localparam int LW_DEFAULT = 3;

endpackage : dm_arbiter_pkg

// File: rtl/dm_rr_pick.sv
// ---------------------------------------------------------------------------
// dm_rr_pick
// Two-way round-robin pick. A single requester always wins; when both
// request, the port that was not granted last wins.
// Ports:
//   req[1:0]  in   request vector (bit 0 = port 0, bit 1 = port 1)
//   last      in   index of the port granted most recently
//   gnt[1:0]  out  one-hot winner, all-zero when nobody requests
// ---------------------------------------------------------------------------
module dm_rr_pick
    import dm_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt
);

    always_comb begin
        // NOTE: default first so every path assigns gnt and no latch is inferred.
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = (last == PORT1) ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end

endmodule : dm_rr_pick

// File: rtl/dm_arbiter.sv
// ---------------------------------------------------------------------------
// dm_arbiter
// Arbitrates a single-ported memory between a CPU port (port 0, single
// accesses) and a DMA port (port 1, single writes or read bursts of up to
// 2^LW words). A command is accepted combinationally in IDLE, latched on
// the grant edge, and replayed to the memory from the latched copy.
// Ports:
//   CLK, Reset                   clock, async active-low reset
//   Req0/Wr0/A0/WD0              port-0 command
//   Gnt0, RValid0, RD0           port-0 accept strobe and read return
//   Req1/Wr1/A1/WD1/Len1         port-1 command (Len1 = read beats - 1)
//   Gnt1, RValid1, RD1, Done1    port-1 accept, read return, completion
//   MemWr/MemA/MemWD, MemRD      memory side (MemRD combinational from MemA)
// ---------------------------------------------------------------------------
module dm_arbiter
    import dm_arbiter_pkg::*;
#(
    parameter int AW = 32,
    parameter int DW = 32,
    parameter int LW = LW_DEFAULT
) (
    input  logic          CLK,
    input  logic          Reset,
    input  logic          Req0,
    input  logic          Wr0,
    input  logic [AW-1:0] A0,
    input  logic [DW-1:0] WD0,
    output logic          Gnt0,
    output logic          RValid0,
    output logic [DW-1:0] RD0,
    input  logic          Req1,
    input  logic          Wr1,
    input  logic [AW-1:0] A1,
    input  logic [DW-1:0] WD1,
    input  logic [LW-1:0] Len1,
    output logic          Gnt1,
    output logic          RValid1,
    output logic [DW-1:0] RD1,
    output logic          Done1,
    output logic          MemWr,
    output logic [AW-1:0] MemA,
    output logic [DW-1:0] MemWD,
    input  logic [DW-1:0] MemRD
);

    logic [1:0]    state;
    logic          last;      // port granted most recently
    logic          cmd_wr;
    logic [AW-1:0] cmd_a;     // current beat address
    logic [DW-1:0] cmd_wd;
    logic [LW-1:0] cmd_cnt;   // beats remaining after the current one
    logic [1:0]    pick;
    logic          idle;
    logic          busy;

    dm_rr_pick u_pick (
        .req  ({Req1, Req0}),
        .last (last),
        .gnt  (pick)
    );

    assign idle = (state == ST_IDLE);
    assign busy = !idle;

    // Grants are combinational from the requests, so they are also gated by
    // Reset to make every output read zero while reset is held.
    assign Gnt0 = Reset & idle & pick[0];
    assign Gnt1 = Reset & idle & pick[1];

    // Memory side is driven only from the latched command; zero in IDLE.
    assign MemWr = busy & cmd_wr;
    assign MemA  = busy ? cmd_a  : '0;
    assign MemWD = busy ? cmd_wd : '0;

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values regardless of statement order.
            state   <= ST_IDLE;
            last    <= PORT1;
            cmd_wr  <= 1'b0;
            cmd_a   <= '0;
            cmd_wd  <= '0;
            cmd_cnt <= '0;
            RValid0 <= 1'b0;
            RD0     <= '0;
            RValid1 <= 1'b0;
            RD1     <= '0;
            Done1   <= 1'b0;
        end else begin
            RValid0 <= 1'b0;
            RValid1 <= 1'b0;
            Done1   <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (Gnt0) begin
                        state   <= ST_ACC0;
                        cmd_wr  <= Wr0;
                        cmd_a   <= A0;
                        cmd_wd  <= WD0;
                        cmd_cnt <= '0;
                    end else if (Gnt1) begin
                        state   <= ST_ACC1;
                        cmd_wr  <= Wr1;
                        cmd_a   <= A1;
                        cmd_wd  <= WD1;
                        // Writes are always a single beat.
                        cmd_cnt <= Wr1 ? '0 : Len1;
                    end
                end
                ST_ACC0: begin
                    if (!cmd_wr) begin
                        RValid0 <= 1'b1;
                        RD0     <= MemRD;
                    end
                    state <= ST_IDLE;
                    last  <= PORT0;
                end
                ST_ACC1: begin
                    if (!cmd_wr) begin
                        RValid1 <= 1'b1;
                        RD1     <= MemRD;
                    end
                    if (cmd_cnt == '0) begin
                        Done1 <= 1'b1;
                        state <= ST_IDLE;
                        last  <= PORT1;
                    end else begin
                        // Address wraps naturally at 2^AW.
                        cmd_a   <= cmd_a + AW'(4);
                        cmd_cnt <= cmd_cnt - LW'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule : dm_arbiter

// File: doc/dm_arbiter.md
DM_ARBITER -- requirements
Module: dm_arbiter

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
  AW, 32, address width
  DW, 32, data width
  LW, 3, port-1 burst length field width (max burst = 2^LW words)
REQ-002 Ports SHALL be (name  direction  width  meaning):
  CLK  in  1  single clock, all state on rising edge
  Reset  in  1  asynchronous, active-low reset (asserted at 0)
  Req0  in  1  port-0 (CPU) access request
  Wr0  in  1  port-0 write (1) / read (0)
  A0  in  AW  port-0 byte address
  WD0  in  DW  port-0 write data
  Gnt0  out  1  port-0 command accepted this cycle
  RValid0  out  1  port-0 read data valid
  RD0  out  DW  port-0 read data
  Req1  in  1  port-1 (DMA) access request
  Wr1  in  1  port-1 write / read
  A1  in  AW  port-1 start byte address
  WD1  in  DW  port-1 write data
  Len1  in  LW  port-1 read burst length minus one
  Gnt1  out  1  port-1 command accepted this cycle
  RValid1  out  1  port-1 read data valid
  RD1  out  DW  port-1 read data
  Done1  out  1  port-1 final beat / write complete
  MemWr  out  1  memory write enable
  MemA  out  AW  memory byte address
  MemWD  out  DW  memory write data
  MemRD  in  DW  memory read data, combinational from MemA

Function
REQ-003 FSM SHALL have states IDLE, ACC0, ACC1.
REQ-004 In IDLE with Req0 or Req1 high, GntX SHALL assert combinationally for exactly one winner that cycle.
REQ-005 Winner: single requester wins; both high -> port not last granted wins (round-robin pointer).
REQ-006 On the Gnt edge the command (Wr, A, WD, Len) SHALL be latched; FSM moves to ACCx.
REQ-007 Requester SHALL hold Req/Wr/A/WD/Len stable until its Gnt; dropping Req before Gnt cancels without effect.
REQ-008 In ACCx MemA/MemWr/MemWD SHALL come from latched command only; in IDLE MemWr=0, MemA=0, MemWD=0.
REQ-009 Read: Gnt at cycle T, memory access T+1, RDx registered from MemRD, RValidx=1 for one cycle at T+2.
REQ-010 Write: MemWr=1 for one cycle at T+1; no RValid; Done1 pulses at T+2 for port-1 writes.
REQ-011 Port-1 read burst SHALL stay in ACC1 for Len1+1 cycles, MemA += 4 per beat, modulo 2^AW wraparound.
REQ-012 RValid1 SHALL pulse once per beat, one cycle after each access; Done1 coincides with last RValid1.
REQ-013 Port-1 writes are single-beat; Len1 ignored when Wr1=1.
REQ-014 On leaving ACCx FSM SHALL return to IDLE; pointer set to x; next grant possible the following cycle.
REQ-015 Req held high after Gnt SHALL be treated as a new request at the next IDLE.
REQ-016 Address low bits SHALL pass unmodified; alignment is the memory's concern.

Reset
REQ-017 Reset low SHALL immediately force IDLE, pointer = port 1 (port 0 wins first tie), all outputs 0, latched command cleared.
REQ-018 Reset mid-access or mid-burst SHALL abandon the operation with no further RValid/Done.

Structure
REQ-019 Shared package SHALL hold state encoding, port index constants, and LW default.
REQ-020 The two-way round-robin pick SHALL be sub-module dm_rr_pick (req[1:0], last -> gnt[1:0]).

Verification
REQ-021 Req0 read A0=0x10, mem[4]=0xDEADBEEF -> Gnt0 cycle T, MemA=0x10 at T+1, RValid0 with RD0=0xDEADBEEF at T+2.
REQ-022 Req0 and Req1 together after reset -> Gnt0 first; both held -> Gnt1 next, then Gnt0 alternating.
REQ-023 Req1 read A1=0x20, Len1=3 -> MemA 0x20,0x24,0x28,0x2C on consecutive cycles; four RValid1; Done1 on fourth.
REQ-024 Req1 write A1=0x40, WD1=0x12345678 -> single MemWr pulse, MemA=0x40, Done1 one cycle later, no RValid1.
REQ-025 Reset low during beat 2 of 4-beat burst -> all outputs 0 same cycle, no Done1, IDLE after release.
REQ-026 Burst A1=0xFFFFFFF8, Len1=3 -> MemA 0xFFFFFFF8, 0xFFFFFFFC, 0x0, 0x4.
